// File: rtl/multiword_adder_seq_pkg.sv
// Shared types and helpers for the multi-word sequential adder.
//   state_t : sequencer states IDLE / RUN / DONE
//   idx_w() : slice-counter width for K slices (at least 1 bit)
package mwadd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width for K slices; a single slice still needs one bit.
    function automatic int unsigned idx_w(input int unsigned k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/multiword_adder_seq_if.sv
// Operand and result handshakes of multiword_adder_seq.
//   in_valid/in_ready carry a, b, cin into the block.
//   out_valid/out_ready carry sum, cout (and ovf with MWADD_OVF_EN) out.
//   master: producer/consumer side. slave: the adder.
// Optional macro: MWADD_OVF_EN adds the signed-overflow flag ovf.
interface multiword_adder_seq_if #(
    parameter int unsigned N = 8,
    parameter int unsigned K = 4
);
    localparam int unsigned W = N * K;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef MWADD_OVF_EN
    logic         ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
`ifdef MWADD_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
`ifdef MWADD_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/multiword_adder_seq_rca.sv
// N-bit ripple-carry adder: the single slice adder reused every RUN cycle.
//   a, b : N-bit addends   cin : carry in
//   sum  : N-bit sum       cout: carry out of bit N-1
module ripple_carry_adder #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[N];

endmodule

// File: rtl/multiword_adder_seq.sv
// Multi-precision adder: adds two W = N*K bit operands one N-bit slice per
// cycle, LSB slice first, through a single ripple_carry_adder.
//   clk, rst : clock, synchronous active-high reset
//   bus      : multiword_adder_seq_if.slave (operand and result handshakes)
// Optional macro: MWADD_OVF_EN adds signed overflow flag bus.ovf.
import mwadd_pkg::*;

module multiword_adder_seq #(
    parameter int unsigned N = 8,
    parameter int unsigned K = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    multiword_adder_seq_if.slave bus
);

    localparam int unsigned W  = N * K;
    localparam int unsigned IW = idx_w(K);

    state_t        state;
    logic [W-1:0]  opa;
    logic [W-1:0]  opb;
    logic [W-1:0]  sum_r;
    logic          carry_r;
    logic          cout_r;
    logic          in_ready_r;
    logic          out_valid_r;
    logic [IW-1:0] idx;

    logic [N-1:0]  slice_sum;
    logic          slice_co;
    logic [W-1:0]  opa_shift;
    logic [W-1:0]  opb_shift;
    logic [W-1:0]  sum_shift;

`ifdef MWADD_OVF_EN
    logic          a_msb;
    logic          b_msb;
    logic          ovf_r;
`endif

    ripple_carry_adder #(.N(N)) u_rca (
        .a    (opa[N-1:0]),
        .b    (opb[N-1:0]),
        .cin  (carry_r),
        .sum  (slice_sum),
        .cout (slice_co)
    );

    // Shift paths; with one slice the new sum slice is the whole result.
    if (K == 1) begin : g_one
        assign opa_shift = '0;
        assign opb_shift = '0;
        assign sum_shift = slice_sum;
    end else begin : g_multi
        assign opa_shift = {{N{1'b0}}, opa[W-1:N]};
        assign opb_shift = {{N{1'b0}}, opb[W-1:N]};
        assign sum_shift = {slice_sum, sum_r[W-1:N]};
    end

    // Sequencer, operand/sum shift registers and slice carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            opa         <= '0;
            opb         <= '0;
            sum_r       <= '0;
            carry_r     <= 1'b0;
            cout_r      <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            idx         <= '0;
`ifdef MWADD_OVF_EN
            a_msb       <= 1'b0;
            b_msb       <= 1'b0;
            ovf_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_ready_r && bus.in_valid) begin
                        opa        <= bus.a;
                        opb        <= bus.b;
                        carry_r    <= bus.cin;
                        idx        <= '0;
                        in_ready_r <= 1'b0;
                        state      <= RUN;
`ifdef MWADD_OVF_EN
                        a_msb      <= bus.a[W-1];
                        b_msb      <= bus.b[W-1];
                        ovf_r      <= 1'b0;
`endif
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                RUN: begin
                    opa     <= opa_shift;
                    opb     <= opb_shift;
                    sum_r   <= sum_shift;
                    carry_r <= slice_co;
                    idx     <= idx + IW'(1);
                    if (idx == IW'(K - 1)) begin
                        cout_r      <= slice_co;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
`ifdef MWADD_OVF_EN
                        // slice_sum[N-1] becomes the result MSB on this edge.
                        ovf_r <= (a_msb == b_msb) && (slice_sum[N-1] != a_msb);
`endif
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
`ifdef MWADD_OVF_EN
    assign bus.ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_multiword_adder_seq.sv
// Directed self-checking bench for multiword_adder_seq with N=8, K=4.
module tb_multiword_adder_seq;

    localparam int unsigned N = 8;
    localparam int unsigned K = 4;
    localparam int unsigned W = N * K;

    logic clk;
    logic rst;

    multiword_adder_seq_if #(.N(N), .K(K)) bus ();

    multiword_adder_seq #(.N(N), .K(K)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an operand pair and return just after the accepting edge.
    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
        int t;
        bus.in_valid = 1'b1;
        bus.a        = va;
        bus.b        = vb;
        bus.cin      = vc;
        t = 0;
        while (!bus.in_ready && t < 20) begin
            step();
            t++;
        end
        if (t >= 20) chk("send_timeout", 64'(t), 64'd0);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
        if (lat >= 20) chk("out_timeout", 64'(lat), 64'd0);
    endtask

    // Full op with out_ready high: latency, sum, cout (and ovf), then handshake.
    task automatic run_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vc, input logic [W-1:0] es, input logic ec,
                          input logic eo);
        int lat;
        bus.out_ready = 1'b1;
        send(va, vb, vc);
        wait_out(lat);
        chk({tag, "_lat"}, 64'(lat), 64'(K));
        chk({tag, "_sum"}, 64'(bus.sum), 64'(es));
        chk({tag, "_cout"}, 64'(bus.cout), 64'(ec));
`ifdef MWADD_OVF_EN
        chk({tag, "_ovf"}, 64'(bus.ovf), 64'(eo));
`else
        if (eo) begin end
`endif
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          t;
        int          acc;
        int          res;
        int          last;
        bit          seen;
        logic [W:0]  expq [$];
        logic [W:0]  e;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic        rc;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_sum", 64'(bus.sum), 64'd0);
        chk("rst_cout", 64'(bus.cout), 64'd0);
`ifdef MWADD_OVF_EN
        chk("rst_ovf", 64'(bus.ovf), 64'd0);
`endif
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Full carry ripple and carry-in
        run_op("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_op("cin", 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0);

        // Backpressure: result held while out_ready is low, new in_valid ignored
        bus.out_ready = 1'b0;
        send(32'h8000_0001, 32'h8000_0002, 1'b0);
        bus.in_valid = 1'b1;
        bus.a        = 32'h1111_1111;
        bus.b        = 32'h2222_2222;
        bus.cin      = 1'b0;
        wait_out(lat);
        chk("bp_lat", 64'(lat), 64'(K));
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_sum", 64'(bus.sum), 64'h0000_0003);
            chk("bp_cout", 64'(bus.cout), 64'd1);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            step();
        end
        bus.out_ready = 1'b1;
        step();
        chk("bp_release_valid", 64'(bus.out_valid), 64'd0);
        chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
        step();
        chk("bp_accept2", 64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b0;
        wait_out(lat);
        chk("bp2_lat", 64'(lat), 64'(K));
        chk("bp2_sum", 64'(bus.sum), 64'h3333_3333);
        chk("bp2_cout", 64'(bus.cout), 64'd0);
        step();

        // Reset during the second RUN cycle aborts the op
        send(32'hDEAD_BEEF, 32'h0123_4567, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_in_ready", 64'(bus.in_ready), 64'd0);
        seen = 1'b0;
        step();
        chk("abort_idle_ready", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid) seen = 1'b1;
            step();
        end
        chk("abort_never_valid", 64'(seen), 64'd0);
        run_op("after_abort", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);

        // Signed overflow cases
        run_op("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_op("ovf_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0);

        // Back-to-back throughput against a reference sum
        bus.out_ready = 1'b1;
        acc  = 0;
        res  = 0;
        last = 0;
        t    = 0;
        while (res < 10 && t < 300) begin
            if (bus.out_valid) begin
                if (expq.size() == 0) begin
                    chk("tput_unexpected", 64'd1, 64'd0);
                end else begin
                    e = expq.pop_front();
                    chk("tput_sum", 64'(bus.sum), 64'(e[W-1:0]));
                    chk("tput_cout", 64'(bus.cout), 64'(e[W]));
                end
                res++;
            end
            if (bus.in_ready) begin
                if (acc < 10) begin
                    ra = $urandom;
                    rb = $urandom;
                    rc = 1'($urandom_range(0, 1));
                    bus.in_valid = 1'b1;
                    bus.a        = ra;
                    bus.b        = rb;
                    bus.cin      = rc;
                    expq.push_back({1'b0, ra} + {1'b0, rb} + (W+1)'(rc));
                    if (acc > 0) chk("tput_spacing", 64'(t - last), 64'(K + 2));
                    last = t;
                    acc++;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            step();
            t++;
        end
        bus.in_valid = 1'b0;
        chk("tput_results", 64'(res), 64'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
